scan_unload_checker: RTL



---
 rtl/scan_unload_checker_if.sv | 31 +++
 rtl/scan_unload_checker.sv | 97 +++++++++
 2 files changed

// File: rtl/scan_unload_checker_if.sv
// rtl/scan_unload_checker_if.sv - controller/chain-side signal bundle for scan_unload_checker
interface scan_unload_checker_if #(
  parameter int IDX_W  = 4,
  parameter int PAT_W  = 16,
  parameter int FAIL_W = 8
);
  logic              start;
  logic              clr;
  logic              so;
  logic              exp;
  logic              msk;
  logic              se;
  logic              busy;
  logic [IDX_W-1:0]  bit_idx;
  logic              done;
  logic [PAT_W-1:0]  pat_num;
  logic              fail;
  logic [FAIL_W-1:0] fail_cnt;
  logic [PAT_W-1:0]  first_pat;
  logic [IDX_W-1:0]  first_bit;

  modport master (
    output start, clr, so, exp, msk,
    input  se, busy, bit_idx, done, pat_num, fail, fail_cnt, first_pat, first_bit
  );

  modport slave (
    input  start, clr, so, exp, msk,
    output se, busy, bit_idx, done, pat_num, fail, fail_cnt, first_pat, first_bit
  );
endinterface

// File: rtl/scan_unload_checker.sv
// rtl/scan_unload_checker.sv - single-chain scan unload with masked compare and fail logging
module scan_unload_checker #(
  parameter int CHAIN_LEN = 8,
  parameter int IDX_W     = 4,
  parameter int PAT_W     = 16,
  parameter int FAIL_W    = 8
) (
  input  logic                  i_ck,
  input  logic                  i_rst,
  scan_unload_checker_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(CHAIN_LEN - 1);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_done;
  logic [PAT_W-1:0]  r_pat_num;
  logic              r_fail;
  logic [FAIL_W-1:0] r_fail_cnt;
  logic [PAT_W-1:0]  r_first_pat;
  logic [IDX_W-1:0]  r_first_bit;
  logic              w_last;
  logic              w_miscmp;

  assign w_last   = (r_bit_idx == LP_LAST);
  assign w_miscmp = (r_state == SHIFT) && bus.msk && (bus.so != bus.exp);

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = CAPT;
      CAPT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_bit_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == CAPT);
      if (r_state == IDLE && bus.start) r_bit_idx <= '0;
      else if (r_state == SHIFT)        r_bit_idx <= w_last ? '0 : r_bit_idx + 1'b1;
    end
  end

  // clr wins over both the end-of-pattern increment and any miscompare on the same edge
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_pat_num   <= '0;
      r_fail      <= 1'b0;
      r_fail_cnt  <= '0;
      r_first_pat <= '0;
      r_first_bit <= '0;
    end else if (bus.clr) begin
      r_pat_num   <= '0;
      r_fail      <= 1'b0;
      r_fail_cnt  <= '0;
      r_first_pat <= '0;
      r_first_bit <= '0;
    end else begin
      if (r_state == CAPT) r_pat_num <= r_pat_num + 1'b1;
      if (w_miscmp) begin
        r_fail <= 1'b1;
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
        if (!r_fail) begin
          r_first_pat <= r_pat_num;
          r_first_bit <= r_bit_idx;
        end
      end
    end
  end

  assign bus.se        = (r_state == SHIFT);
  assign bus.busy      = (r_state != IDLE);
  assign bus.bit_idx   = r_bit_idx;
  assign bus.done      = r_done;
  assign bus.pat_num   = r_pat_num;
  assign bus.fail      = r_fail;
  assign bus.fail_cnt  = r_fail_cnt;
  assign bus.first_pat = r_first_pat;
  assign bus.first_bit = r_first_bit;
endmodule
